// File: rtl/packet_merge_pkg.sv
// Shared definitions for the packet stream merger.
// Contents:
//   wr_state_t  - per-input writer states (SYNC, START, ACCEPT, DISCARD)
//   arb_state_t - output arbiter states (IDLE, SEND)
//   free_space  - FIFO free words from (addr_width+1)-bit write/read pointers
package packet_merge_pkg;

    typedef enum logic [1:0] {
        WR_SYNC    = 2'd0,
        WR_START   = 2'd1,
        WR_ACCEPT  = 2'd2,
        WR_DISCARD = 2'd3
    } wr_state_t;

    typedef enum logic {
        ARB_IDLE = 1'b0,
        ARB_SEND = 1'b1
    } arb_state_t;

    // Pointers carry one extra wrap bit, so the occupancy is their difference
    // taken modulo 2**(addr_width+1).
    function automatic int unsigned free_space(input int unsigned wr_ptr,
                                               input int unsigned rd_ptr,
                                               input int unsigned addr_width);
        int unsigned used;
        used = (wr_ptr - rd_ptr) & ((32'd1 << (addr_width + 1)) - 32'd1);
        return (32'd1 << addr_width) - used;
    endfunction

endpackage

// File: rtl/packet_fifo.sv
// Per-input packet FIFO with its own writer state machine.
// Words of a packet become visible to the reader only once the whole packet
// (or its truncated prefix) has been written and committed.
// Ports:
//   clk, aresetn            - clock, asynchronous active-low reset
//   in_data/in_valid/in_last- non-backpressurable input stream
//   pop                     - advance the read pointer past the head word
//   pkt_done                - reader finished one packet (tlast handshaken)
//   head_data/head_last     - registered head word of the FIFO
//   pkt_avail               - at least one committed packet is stored
//   drop_count/trunc_count  - saturating statistics counters
module packet_fifo
    import packet_merge_pkg::*;
#(
    parameter int DATA_WIDTH       = 16,
    parameter int FIFO_ADDR_WIDTH  = 6,
    parameter int MAX_PACKET_WORDS = 32,
    parameter int COUNTER_WIDTH    = 16
) (
    input  logic                     clk,
    input  logic                     aresetn,
    input  logic [DATA_WIDTH-1:0]    in_data,
    input  logic                     in_valid,
    input  logic                     in_last,
    input  logic                     pop,
    input  logic                     pkt_done,
    output logic [DATA_WIDTH-1:0]    head_data,
    output logic                     head_last,
    output logic                     pkt_avail,
    output logic [COUNTER_WIDTH-1:0] drop_count,
    output logic [COUNTER_WIDTH-1:0] trunc_count
);

    localparam int DEPTH = 2 ** FIFO_ADDR_WIDTH;
    localparam int WCW   = $clog2(MAX_PACKET_WORDS + 1);

    wr_state_t                  wr_state_reg, wr_state_next;
    logic [FIFO_ADDR_WIDTH:0]   wr_ptr_reg, rd_ptr_reg, rd_ptr_next;
    logic [FIFO_ADDR_WIDTH:0]   pkt_cnt_reg;
    logic [WCW-1:0]             word_cnt_reg;
    logic                       commit_reg;
    logic [COUNTER_WIDTH-1:0]   drop_cnt_reg, trunc_cnt_reg;
    logic [DATA_WIDTH:0]        mem [DEPTH];
    logic [DATA_WIDTH:0]        head_word_reg;

    logic wr_en, wr_last, commit_now, drop_now, trunc_now;
    logic space_ok, at_limit, fifo_full;

    assign space_ok  = int'(free_space(32'(wr_ptr_reg), 32'(rd_ptr_reg), FIFO_ADDR_WIDTH))
                       >= MAX_PACKET_WORDS;
    // The word now arriving in ACCEPT would be word number MAX_PACKET_WORDS.
    assign at_limit  = (word_cnt_reg == WCW'(MAX_PACKET_WORDS - 1));
    assign fifo_full = (wr_ptr_reg[FIFO_ADDR_WIDTH] != rd_ptr_reg[FIFO_ADDR_WIDTH]) &&
                       (wr_ptr_reg[FIFO_ADDR_WIDTH-1:0] == rd_ptr_reg[FIFO_ADDR_WIDTH-1:0]);
    assign rd_ptr_next = rd_ptr_reg + (FIFO_ADDR_WIDTH + 1)'(pop);

    // Writer state register
    always_ff @(posedge clk or negedge aresetn) begin
        if (!aresetn) wr_state_reg <= WR_SYNC;
        else          wr_state_reg <= wr_state_next;
    end

    // Writer next state
    always_comb begin
        wr_state_next = wr_state_reg;
        case (wr_state_reg)
            WR_SYNC:    if (!in_valid || in_last) wr_state_next = WR_START;
            WR_START:   if (in_valid && !in_last)
                            wr_state_next = space_ok ? WR_ACCEPT : WR_DISCARD;
            WR_ACCEPT:  if (in_valid) begin
                            if (in_last)      wr_state_next = WR_START;
                            else if (at_limit) wr_state_next = WR_DISCARD;
                        end
            WR_DISCARD: if (in_valid && in_last) wr_state_next = WR_START;
            default:    wr_state_next = WR_SYNC;
        endcase
    end

    // Writer outputs
    always_comb begin
        wr_en      = 1'b0;
        wr_last    = in_last;
        commit_now = 1'b0;
        drop_now   = 1'b0;
        trunc_now  = 1'b0;
        case (wr_state_reg)
            WR_START: if (in_valid) begin
                if (space_ok) begin
                    wr_en      = 1'b1;
                    commit_now = in_last;
                end else begin
                    drop_now = 1'b1;
                end
            end
            WR_ACCEPT: if (in_valid) begin
                wr_en = 1'b1;
                if (in_last) begin
                    commit_now = 1'b1;
                end else if (at_limit) begin
                    wr_last    = 1'b1;
                    commit_now = 1'b1;
                    trunc_now  = 1'b1;
                end
            end
            default: ;
        endcase
    end

    // Pointers, commit pipeline and counters. The commit is delayed by one
    // cycle so the registered head read has seen the last written word
    // before the packet becomes visible.
    always_ff @(posedge clk or negedge aresetn) begin
        if (!aresetn) begin
            wr_ptr_reg    <= '0;
            rd_ptr_reg    <= '0;
            pkt_cnt_reg   <= '0;
            word_cnt_reg  <= '0;
            commit_reg    <= 1'b0;
            drop_cnt_reg  <= '0;
            trunc_cnt_reg <= '0;
        end else begin
            rd_ptr_reg <= rd_ptr_next;
            commit_reg <= commit_now;
            if (wr_en) begin
                wr_ptr_reg   <= wr_ptr_reg + 1'b1;
                word_cnt_reg <= (wr_state_reg == WR_START) ? WCW'(1) : word_cnt_reg + 1'b1;
            end
            case ({commit_reg, pkt_done})
                2'b10:   pkt_cnt_reg <= pkt_cnt_reg + 1'b1;
                2'b01:   pkt_cnt_reg <= pkt_cnt_reg - 1'b1;
                default: ;
            endcase
            if (drop_now && drop_cnt_reg != '1)   drop_cnt_reg  <= drop_cnt_reg + 1'b1;
            if (trunc_now && trunc_cnt_reg != '1) trunc_cnt_reg <= trunc_cnt_reg + 1'b1;
        end
    end

    // Storage with a registered show-ahead read: the head register follows
    // the next read address every cycle, so it is refreshed even when the
    // head location was being written on the previous edge.
    always_ff @(posedge clk) begin
        if (wr_en) mem[wr_ptr_reg[FIFO_ADDR_WIDTH-1:0]] <= {wr_last, in_data};
        head_word_reg <= mem[rd_ptr_next[FIFO_ADDR_WIDTH-1:0]];
    end

    assert property (@(posedge clk) disable iff (!aresetn) wr_en |-> !fifo_full);

    assign head_data   = head_word_reg[DATA_WIDTH-1:0];
    assign head_last   = head_word_reg[DATA_WIDTH];
    assign pkt_avail   = (pkt_cnt_reg != '0);
    assign drop_count  = drop_cnt_reg;
    assign trunc_count = trunc_cnt_reg;

endmodule

// File: rtl/packet_stream_merger.sv
// Merges INPUT_COUNT non-backpressurable packet streams onto one AXI stream.
// Each input is buffered in a packet_fifo; a round-robin arbiter forwards
// whole committed packets through a registered output stage.
// Ports:
//   clk, aresetn                  - Aurora user clock, async active-low reset
//   inTDATA/inTVALID/inTLAST      - packed input streams, input i at slice i
//   outTDATA/outTVALID/outTLAST   - merged output stream
//   outTREADY                     - merged output ready
//   dropCount/truncCount          - packed per-input statistics
//   outPacketCount                - packets completed on the output
module packet_stream_merger
    import packet_merge_pkg::*;
#(
    parameter int INPUT_COUNT      = 2,
    parameter int DATA_WIDTH       = 16,
    parameter int FIFO_ADDR_WIDTH  = 6,
    parameter int MAX_PACKET_WORDS = 32,
    parameter int COUNTER_WIDTH    = 16,
    parameter     DEBUG            = "false"
) (
    input  logic                                 clk,
    input  logic                                 aresetn,
    input  logic [INPUT_COUNT*DATA_WIDTH-1:0]    inTDATA,
    input  logic [INPUT_COUNT-1:0]               inTVALID,
    input  logic [INPUT_COUNT-1:0]               inTLAST,
    output logic [DATA_WIDTH-1:0]                outTDATA,
    output logic                                 outTVALID,
    output logic                                 outTLAST,
    input  logic                                 outTREADY,
    output logic [INPUT_COUNT*COUNTER_WIDTH-1:0] dropCount,
    output logic [INPUT_COUNT*COUNTER_WIDTH-1:0] truncCount,
    output logic [COUNTER_WIDTH-1:0]             outPacketCount
);

    localparam int SEL_W = (INPUT_COUNT > 1) ? $clog2(INPUT_COUNT) : 1;

    (* mark_debug = DEBUG *) arb_state_t      arb_state_reg;
    arb_state_t                               arb_state_next;
    (* mark_debug = DEBUG *) logic [DATA_WIDTH-1:0] out_data_reg;
    (* mark_debug = DEBUG *) logic            out_valid_reg;
    (* mark_debug = DEBUG *) logic            out_last_reg;
    logic [SEL_W-1:0]                         grant_reg, rr_ptr_reg, rr_ptr_next;
    logic [COUNTER_WIDTH-1:0]                 out_pkt_cnt_reg;

    logic [DATA_WIDTH-1:0] head_data [INPUT_COUNT];
    logic [INPUT_COUNT-1:0] head_last, pkt_avail, pop, pkt_done;
    logic [SEL_W-1:0]       sel_idx, pop_sel;
    logic                   sel_found, load_word, done_pkt, handshake;

    generate
        for (genvar gi = 0; gi < INPUT_COUNT; gi++) begin : g_in
            packet_fifo #(
                .DATA_WIDTH       (DATA_WIDTH),
                .FIFO_ADDR_WIDTH  (FIFO_ADDR_WIDTH),
                .MAX_PACKET_WORDS (MAX_PACKET_WORDS),
                .COUNTER_WIDTH    (COUNTER_WIDTH)
            ) u_fifo (
                .clk         (clk),
                .aresetn     (aresetn),
                .in_data     (inTDATA[gi*DATA_WIDTH +: DATA_WIDTH]),
                .in_valid    (inTVALID[gi]),
                .in_last     (inTLAST[gi]),
                .pop         (pop[gi]),
                .pkt_done    (pkt_done[gi]),
                .head_data   (head_data[gi]),
                .head_last   (head_last[gi]),
                .pkt_avail   (pkt_avail[gi]),
                .drop_count  (dropCount[gi*COUNTER_WIDTH +: COUNTER_WIDTH]),
                .trunc_count (truncCount[gi*COUNTER_WIDTH +: COUNTER_WIDTH])
            );
            assign pop[gi]      = load_word && (int'(pop_sel) == gi);
            assign pkt_done[gi] = done_pkt && (int'(grant_reg) == gi);
        end
    endgenerate

    // Round-robin search starting at rr_ptr_reg, wrapping at INPUT_COUNT.
    always_comb begin
        int cand;
        cand      = 0;
        sel_found = 1'b0;
        sel_idx   = '0;
        for (int k = 0; k < INPUT_COUNT; k++) begin
            cand = (int'(rr_ptr_reg) + k) % INPUT_COUNT;
            if (!sel_found && pkt_avail[SEL_W'(cand)]) begin
                sel_found = 1'b1;
                sel_idx   = SEL_W'(cand);
            end
        end
    end

    assign handshake   = out_valid_reg && outTREADY;
    assign rr_ptr_next = (int'(grant_reg) == INPUT_COUNT - 1) ? '0 : grant_reg + SEL_W'(1);

    // Arbiter state register
    always_ff @(posedge clk or negedge aresetn) begin
        if (!aresetn) arb_state_reg <= ARB_IDLE;
        else          arb_state_reg <= arb_state_next;
    end

    // Arbiter next state
    always_comb begin
        arb_state_next = arb_state_reg;
        case (arb_state_reg)
            ARB_IDLE: if (sel_found) arb_state_next = ARB_SEND;
            ARB_SEND: if (handshake && out_last_reg) arb_state_next = ARB_IDLE;
            default:  arb_state_next = ARB_IDLE;
        endcase
    end

    // Arbiter outputs: which FIFO to pop and when a packet finishes
    always_comb begin
        load_word = 1'b0;
        done_pkt  = 1'b0;
        pop_sel   = grant_reg;
        case (arb_state_reg)
            ARB_IDLE: begin
                pop_sel   = sel_idx;
                load_word = sel_found;
            end
            ARB_SEND: if (handshake) begin
                if (out_last_reg) done_pkt  = 1'b1;
                else              load_word = 1'b1;
            end
            default: ;
        endcase
    end

    // Output register, grant and round-robin pointer
    always_ff @(posedge clk or negedge aresetn) begin
        if (!aresetn) begin
            out_data_reg    <= '0;
            out_valid_reg   <= 1'b0;
            out_last_reg    <= 1'b0;
            grant_reg       <= '0;
            rr_ptr_reg      <= '0;
            out_pkt_cnt_reg <= '0;
        end else begin
            if (arb_state_reg == ARB_IDLE && sel_found) grant_reg <= sel_idx;
            if (load_word) begin
                out_data_reg  <= head_data[pop_sel];
                out_last_reg  <= head_last[pop_sel];
                out_valid_reg <= 1'b1;
            end
            if (done_pkt) begin
                out_valid_reg <= 1'b0;
                rr_ptr_reg    <= rr_ptr_next;
                if (out_pkt_cnt_reg != '1) out_pkt_cnt_reg <= out_pkt_cnt_reg + 1'b1;
            end
        end
    end

    assign outTDATA       = out_data_reg;
    assign outTVALID      = out_valid_reg;
    assign outTLAST       = out_last_reg;
    assign outPacketCount = out_pkt_cnt_reg;

endmodule

// File: doc/packet_stream_merger.md
Name: packet_stream_merger

Overview:
Parametrised replacement for the block-design AXI-stream interconnect that merges the forwarded CW stream and the locally generated packet stream onto the outgoing Aurora link.
- Accepts INPUT_COUNT non-backpressurable packet streams in the Aurora user clock domain.
- Buffers each stream in its own packet FIFO.
- Emits whole packets only, round-robin, on one AXI stream that honours tready.
- Adds per-input drop/truncation accounting, which the interconnect lacks.

Parameters:
INPUT_COUNT, 2, number of input streams (1..8); input 0 has round-robin priority after reset.
DATA_WIDTH, 16, tdata width of every stream.
FIFO_ADDR_WIDTH, 6, per-input FIFO depth is 2**FIFO_ADDR_WIDTH words.
MAX_PACKET_WORDS, 32, largest packet accepted; must be <= 2**FIFO_ADDR_WIDTH.
COUNTER_WIDTH, 16, width of each statistics counter.
DEBUG, "false", mark_debug value applied to the arbiter state and output stream.

Ports:
clk  in  1  Aurora user clock.
aresetn  in  1  Asynchronous active-low reset.
inTDATA  in  INPUT_COUNT*DATA_WIDTH  Input i occupies bits [i*DATA_WIDTH +: DATA_WIDTH].
inTVALID  in  INPUT_COUNT  Per-input valid; there is no inTREADY.
inTLAST  in  INPUT_COUNT  Per-input end of packet.
outTDATA  out  DATA_WIDTH  Merged stream data.
outTVALID  out  1  Merged stream valid.
outTLAST  out  1  Merged stream end of packet.
outTREADY  in  1  Merged stream ready.
dropCount  out  INPUT_COUNT*COUNTER_WIDTH  Per-input count of packets discarded for lack of space.
truncCount  out  INPUT_COUNT*COUNTER_WIDTH  Per-input count of oversize packets truncated.
outPacketCount  out  COUNTER_WIDTH  Packets completed on the output (handshake with tlast).

Behaviour:
Reset:
- aresetn low, asynchronous: all FIFO pointers, counters and outputs go to 0.
- Arbiter goes to IDLE; round-robin pointer goes to input 0.
- Every input writer goes to SYNC.
- Counts restart from 0 after reset.

Input writer, one per input. States SYNC, START, ACCEPT, DISCARD.
- SYNC: words are discarded. Go to START on any cycle with inTVALID=0, or after a tlast word (that word is also discarded). A packet cut by a mid-packet reset is therefore never forwarded.
- START, inTVALID=1: if free space >= MAX_PACKET_WORDS, write the word and go to ACCEPT; otherwise discard it, increment dropCount and go to DISCARD. A single-word packet (tlast on the first word) is written and stays in START.
- ACCEPT: write each valid word. On tlast, the packet is committed (complete-packet counter +1) and the writer returns to START.
- ACCEPT, word number MAX_PACKET_WORDS without tlast: store that word with tlast forced to 1, commit it, increment truncCount, go to DISCARD.
- DISCARD: drop words; return to START after the tlast word.
- All statistics counters saturate at all-ones.

FIFO:
- Stores {tlast, tdata}.
- Uncommitted words are invisible to the arbiter.
- A write and a read in the same cycle are legal.
- A commit and a packet-done in the same cycle leave the complete-packet count unchanged.
- Admission rule guarantees no write ever hits a full FIFO. Full-on-write is an assertion failure.

Arbiter. States IDLE, SEND.
- IDLE: select the first input with complete-packet count > 0, searching from rrPtr upward with wrap. Load its head word into the output register and go to SEND. outTVALID rises the cycle after the decision.
- SEND: on outTVALID && outTREADY, load the next word. When the handshaken word has tlast:
  - set rrPtr to granted input + 1 (mod INPUT_COUNT);
  - decrement that input's packet count;
  - increment outPacketCount;
  - return to IDLE.
- One idle bubble between packets is allowed.
- outTDATA/outTLAST stay stable while outTVALID=1 and outTREADY=0. outTVALID never drops mid-packet.
- Minimum latency: input tlast written at edge N -> committed at N+1 -> arbiter decides at N+1 -> outTVALID at N+2.

Decomposition:
- Shared package packet_merge_pkg holds:
  - writer and arbiter state encodings;
  - the function computing free space = depth - (wrPtr - rdPtr), using FIFO_ADDR_WIDTH+1 pointer bits.
- One natural sub-module: packet_fifo, instantiated per input. It contains the writer state machine, storage, commit logic, counters and a head-word read port.
- The top level contains the arbiter and the output register.

Test Plan:
- Single input, 4-word packet 0x1111..0x1114 with outTREADY=1 -> outTVALID 2 cycles after tlast; 4 words in order; tlast on 0x1114 only; outPacketCount=1.
- Both inputs receive 3-word packets on the same cycle, reset just released -> input 0 packet fully output, then input 1 packet, with no interleaving.
- Input 0 sends 40-word packet (MAX_PACKET_WORDS=32) -> 32 words output, last one with tlast; truncCount[0]=1; next packet on input 0 passes intact.
- outTREADY held low while 3 back-to-back 32-word packets arrive on input 1 (depth 64) -> first two stored, third dropped; dropCount[1]=1; after ready, exactly 64 words output.
- aresetn pulsed low mid-packet on input 0, then the tail of that packet plus one new 2-word packet arrives -> tail discarded, only the 2-word packet output, all counters 0 except outPacketCount=1.
- outTREADY toggled every cycle during a 5-word packet -> data stable whenever ready is low; output sequence identical to the input sequence.
